// File: rtl/ucode_pkg.sv
// Shared types and constants for the microcode store loader.
package ucode_pkg;
   localparam int DEF_W_I        = 9;
   localparam int DEF_W_C        = 26;
   localparam int BYTES_PER_WORD = 4;
   localparam int CSUM_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECV,
      ST_DRAIN,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_t;
endpackage

// File: rtl/ucode_word_packer.sv
// Assembles little-endian boot bytes into words; emits a one-cycle word_valid
// with the word registered alongside it.
module ucode_word_packer
   import ucode_pkg::*;
#(
   parameter int WORD_W = 8 * BYTES_PER_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_last,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);
   localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);

   logic [1:0]         cnt_reg;
   logic [SHIFT_W-1:0] shift_reg;
   logic               word_valid_reg;
   logic [WORD_W-1:0]  word_reg;

   assign byte_last  = (cnt_reg == 2'(BYTES_PER_WORD - 1));
   assign word_valid = word_valid_reg;
   assign word       = word_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg        <= '0;
         shift_reg      <= '0;
         word_valid_reg <= 1'b0;
         word_reg       <= '0;
      end else begin
         word_valid_reg <= 1'b0;
         if (clear) begin
            cnt_reg <= '0;
         end else if (byte_valid) begin
            cnt_reg   <= cnt_reg + 2'd1;
            shift_reg <= {byte_data, shift_reg[SHIFT_W-1:8]};
            // Upper bits beyond WORD_W are dropped on purpose.
            if (byte_last) begin
               word_valid_reg <= 1'b1;
               word_reg       <= WORD_W'({byte_data, shift_reg});
            end
         end
      end
   end
endmodule

// File: rtl/ucode_loader.sv
// Boot-time microcode store loader; holds the core until the store is full.
// Optional trailing checksum byte: define UCODE_LOADER_CHECKSUM_EN.
module ucode_loader
   import ucode_pkg::*;
#(
   parameter int W_I = DEF_W_I,
   parameter int W_C = DEF_W_C
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_valid,
   input  logic [7:0]     s_data,
   output logic           s_ready,
   input  logic           load_req,
   output logic           cs_we,
   output logic [W_I-1:0] cs_addr,
   output logic [W_C-1:0] cs_wdata,
   output logic           core_hold,
   output logic           done,
   output logic           error
);
   state_t         state_reg, state_next;
   logic           s_ready_reg, done_reg, core_hold_reg;
   logic [W_I-1:0] addr_reg;
   logic           xfer, data_xfer, byte_last, word_valid, last_word;

   // A simultaneous load_req wins over any byte transfer.
   assign xfer      = s_valid && s_ready_reg && !load_req;
   assign data_xfer = xfer && (state_reg == ST_RECV);
   assign last_word = &addr_reg;

   ucode_word_packer #(.WORD_W(W_C)) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (state_reg == ST_IDLE),
      .byte_valid (data_xfer),
      .byte_data  (s_data),
      .byte_last  (byte_last),
      .word_valid (word_valid),
      .word       (cs_wdata)
   );

`ifdef UCODE_LOADER_CHECKSUM_EN
   logic [CSUM_W-1:0] csum_reg;
   logic [CSUM_W-1:0] csum_final;
   logic              error_reg;

   assign csum_final = csum_reg + s_data;
   assign error      = error_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_reg  <= '0;
         error_reg <= 1'b0;
      end else begin
         if (state_reg == ST_IDLE)
            csum_reg <= '0;
         else if (data_xfer)
            csum_reg <= csum_final;
         error_reg <= (state_reg == ST_ERR) && !load_req;
      end
   end
`else
   assign error = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      if (load_req) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:  state_next = ST_RECV;
            ST_RECV:  if (xfer && byte_last && last_word) state_next = ST_DRAIN;
`ifdef UCODE_LOADER_CHECKSUM_EN
            ST_DRAIN: state_next = ST_CHECK;
            ST_CHECK: if (xfer) state_next = (csum_final == '0) ? ST_DONE : ST_ERR;
            ST_ERR:   state_next = ST_ERR;
`else
            ST_DRAIN: state_next = ST_DONE;
`endif
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   // Release lags DONE entry by a cycle so the last write settles first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         s_ready_reg   <= 1'b0;
         done_reg      <= 1'b0;
         core_hold_reg <= 1'b1;
         addr_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         s_ready_reg   <= (state_next == ST_RECV) || (state_next == ST_CHECK);
         done_reg      <= (state_reg == ST_DONE) && !load_req;
         core_hold_reg <= !((state_reg == ST_DONE) && !load_req);
         if (state_reg == ST_IDLE)
            addr_reg <= '0;
         else if (word_valid)
            addr_reg <= addr_reg + 1'b1;
      end
   end

   assign s_ready   = s_ready_reg;
   assign cs_we     = word_valid;
   assign cs_addr   = addr_reg;
   assign core_hold = core_hold_reg;
   assign done      = done_reg;
endmodule

// File: tb/tb_ucode_loader.sv
// Scoreboard bench for ucode_loader: random byte streams, queued expected
// writes checked by a negedge monitor.
module tb_ucode_loader;
   localparam int W_I    = 9;
   localparam int W_C    = 26;
   localparam int NWORDS = 1 << W_I;
`ifdef UCODE_LOADER_CHECKSUM_EN
   localparam int LAT = 4 * NWORDS + 4;
`else
   localparam int LAT = 4 * NWORDS + 3;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           s_valid, s_ready, load_req;
   logic [7:0]     s_data;
   logic           cs_we, core_hold, done, error;
   logic [W_I-1:0] cs_addr;
   logic [W_C-1:0] cs_wdata;

   typedef struct {
      int             addr;
      logic [W_C-1:0] data;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         writes_seen = 0;
   int         cyc = 0;
   int         rel_cyc = 0;
   logic [7:0] run_sum;

   ucode_loader #(.W_I(W_I), .W_C(W_C)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .load_req  (load_req),
      .cs_we     (cs_we),
      .cs_addr   (cs_addr),
      .cs_wdata  (cs_wdata),
      .core_hold (core_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0b required=%0b", name, act, req);
      end
   endtask

   task automatic chkn(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Expected store entry: bytes weighted little-endian, reduced mod 2**W_C.
   function automatic logic [W_C-1:0] expect_word(input logic [7:0] b0, input logic [7:0] b1,
                                                   input logic [7:0] b2, input logic [7:0] b3);
      longint v;
      v = longint'(b0) + longint'(b1) * 256 + longint'(b2) * 65536 + longint'(b3) * 16777216;
      return W_C'(v % (longint'(1) << W_C));
   endfunction

   always @(negedge clk) begin
      if (!rst && cs_we) begin
         exp_t e;
         writes_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write actual addr=%0d data=%h required=no write", cs_addr, cs_wdata);
         end else begin
            e = exp_q.pop_front();
            if (int'(cs_addr) != e.addr || cs_wdata !== e.data) begin
               errors++;
               $display("FAIL write actual addr=%0d data=%h required addr=%0d data=%h",
                        cs_addr, cs_wdata, e.addr, e.data);
            end else begin
               $display("wr addr=%0d data=%h ok", cs_addr, cs_wdata);
            end
         end
      end
   end

   // Called at #1 after an edge; returns at #1 after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      logic rdy;
      int   budget;
      while (int'($urandom_range(99)) < gap_pct) begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = b;
      budget  = 0;
      forever begin
         rdy = s_ready;
         @(posedge clk); #1;
         if (rdy) break;
         budget++;
         if (budget > 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=s_ready low required=accept within 100 cycles");
            break;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic send_word(input int w, input logic [31:0] bytes, input int gap_pct);
      logic [7:0] b [4];
      for (int k = 0; k < 4; k++) b[k] = bytes[8*k +: 8];
      exp_q.push_back('{addr: w, data: expect_word(b[0], b[1], b[2], b[3])});
      for (int k = 0; k < 4; k++) begin
         send_byte(b[k], gap_pct);
         run_sum = run_sum + b[k];
      end
   endtask

   task automatic full_load(input bit ramp, input int gap_pct, input bit bad_csum, input bit fresh);
      int          w0;
      logic [31:0] wv;
      w0      = writes_seen;
      run_sum = 8'd0;
      for (int w = 0; w < NWORDS; w++) begin
         if (ramp) wv = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
         else      wv = $urandom;
         send_word(w, wv, gap_pct);
      end
      chk1("drain_ready", s_ready, 1'b0);
      chk1("drain_done", done, 1'b0);
`ifdef UCODE_LOADER_CHECKSUM_EN
      begin
         logic [7:0] trail;
         trail = 8'd0 - run_sum + {7'd0, bad_csum};
         send_byte(trail, 0);
      end
      chk1("csum_edge_done", done, 1'b0);
      @(posedge clk); #1;
      chk1("csum_done", done, !bad_csum);
      chk1("csum_error", error, bad_csum);
      chk1("csum_hold", core_hold, bad_csum);
`else
      @(posedge clk); #1;
      chk1("done_early", done, 1'b0);
      chk1("hold_early", core_hold, 1'b1);
      @(posedge clk); #1;
      chk1("done", done, 1'b1);
      chk1("core_hold", core_hold, 1'b0);
      chk1("error", error, 1'b0);
`endif
      if (fresh) chkn("load_latency", cyc - rel_cyc, LAT);
      chkn("write_count", writes_seen - w0, NWORDS);
      chkn("queue_empty", exp_q.size(), 0);
   endtask

   task automatic pulse_load_req();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      chk1("lr_done", done, 1'b0);
      chk1("lr_hold", core_hold, 1'b1);
      chk1("lr_error", error, 1'b0);
      chk1("lr_idle_ready", s_ready, 1'b0);
      @(posedge clk); #1;
      chk1("lr_recv_ready", s_ready, 1'b1);
      chkn("lr_addr", int'(cs_addr), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk1({tag, "_s_ready"}, s_ready, 1'b0);
      chk1({tag, "_cs_we"}, cs_we, 1'b0);
      chkn({tag, "_cs_addr"}, int'(cs_addr), 0);
      chkn({tag, "_cs_wdata"}, int'(cs_wdata), 0);
      chk1({tag, "_core_hold"}, core_hold, 1'b1);
      chk1({tag, "_done"}, done, 1'b0);
      chk1({tag, "_error"}, error, 1'b0);
   endtask

   initial begin
      rst      = 1'b0;
      s_valid  = 1'b0;
      s_data   = 8'd0;
      load_req = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst     = 1'b0;
      rel_cyc = cyc;

      // Ramp stream straight after reset, exact latency.
      full_load(1'b1, 0, 1'b0, 1'b1);

      // Abort after 3 bytes of word 5, then reload with random data and gaps.
      pulse_load_req();
      run_sum = 8'd0;
      for (int w = 0; w < 5; w++) send_word(w, $urandom, 0);
      for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
      pulse_load_req();
      full_load(1'b0, 50, 1'b0, 1'b0);

`ifdef UCODE_LOADER_CHECKSUM_EN
      pulse_load_req();
      full_load(1'b1, 0, 1'b1, 1'b0);
`endif

      // load_req coincident with byte 3 of word 0 must suppress the write.
      pulse_load_req();
      for (int k = 0; k < 3; k++) send_byte(8'(k + 16), 0);
      chk1("b3_ready", s_ready, 1'b1);
      s_valid  = 1'b1;
      s_data   = 8'hA5;
      load_req = 1'b1;
      @(posedge clk); #1;
      s_valid  = 1'b0;
      load_req = 1'b0;
      chk1("b3_no_we", cs_we, 1'b0);
      chk1("b3_idle_ready", s_ready, 1'b0);
      @(posedge clk); #1;
      chk1("b3_recv_ready", s_ready, 1'b1);
      chk1("b3_no_we_late", cs_we, 1'b0);
      full_load(1'b0, 20, 1'b0, 1'b0);

      // Asynchronous reset from DONE, then reload from entry 0.
      #3 rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      @(posedge clk); #1;
      rst     = 1'b0;
      rel_cyc = cyc;
      full_load(1'b1, 0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
